// File: rtl/seq_shifter_pkg.sv
// Shared definitions for the multi-cycle shifter: select codes, FSM states
// and the effective shift-count rule.
package shifter_pkg;

  localparam logic [3:0] SEL_SRL = 4'b0100;
  localparam logic [3:0] SEL_SLL = 4'b0101;
  localparam logic [3:0] SEL_ROR = 4'b0110;
  localparam logic [3:0] SEL_SRA = 4'b0111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic op_supported(input logic [3:0] op);
    return (op == SEL_SRL) || (op == SEL_SLL) || (op == SEL_ROR) || (op == SEL_SRA);
  endfunction

  // Shifts saturate at width (everything shifted out); rotates wrap modulo width.
  function automatic int unsigned eff_count(input logic [3:0] op,
                                            input int unsigned amount,
                                            input int unsigned width);
    if (!op_supported(op)) return 0;
    if (op == SEL_ROR) return amount & (width - 1);
    return (amount > width) ? width : amount;
  endfunction

endpackage

// File: rtl/seq_shifter_if.sv
// Request/response bundle between the control unit and the shifter.
interface seq_shifter_if #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 8
);
  logic               START;
  logic [3:0]         SELECT;
  logic [WIDTH-1:0]   DATA1;
  logic [SHAMT_W-1:0] DATA2;
  logic [WIDTH-1:0]   RESULT;
  logic               BUSY;
  logic               DONE;
  logic               ERR;

  modport master (output START, SELECT, DATA1, DATA2,
                  input  RESULT, BUSY, DONE, ERR);
  modport slave  (input  START, SELECT, DATA1, DATA2,
                  output RESULT, BUSY, DONE, ERR);
endinterface

// File: rtl/seq_shifter_step.sv
// Combinational single-bit shift/rotate step applied once per SHIFT cycle.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] r_next
);

  always_comb begin
    r_next = r;
    case (op)
      SEL_SRL: r_next = {1'b0, r[WIDTH-1:1]};
      SEL_SLL: r_next = {r[WIDTH-2:0], 1'b0};
      SEL_ROR: r_next = {r[0], r[WIDTH-1:1]};
      SEL_SRA: r_next = {r[WIDTH-1], r[WIDTH-1:1]};
      default: r_next = r;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: one bit position per clock under a START/BUSY/DONE
// handshake; the result register is shifted in place.
module seq_shifter
  import shifter_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int SHAMT_W = 8,
  localparam int CNT_W   = $clog2(WIDTH) + 1
) (
  input  logic CLK,
  input  logic RESET,
  seq_shifter_if.slave bus
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, eff;
  logic [WIDTH-1:0]   res_q, res_d, step_r;
  logic [3:0]         op_q, op_d;
  logic               err_q, err_d;
  logic [SHAMT_W-1:0] amt;
  logic               accept;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op     (op_q),
    .r      (res_q),
    .r_next (step_r)
  );

  assign amt    = bus.DATA2;
  assign accept = bus.START && (state_q != SHIFT);
  assign eff    = CNT_W'(eff_count(bus.SELECT, 32'(amt), WIDTH));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    op_d    = op_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          res_d = bus.DATA1;
          op_d  = bus.SELECT;
          cnt_d = eff;
          if (eff != '0) begin
            state_d = SHIFT;
          end else begin
            state_d = DONE;
            err_d   = !op_supported(bus.SELECT);
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        res_d = step_r;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset also clears the result so a discarded operation leaves nothing behind.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      op_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  assign bus.RESULT = res_q;
  assign bus.BUSY   = (state_q == SHIFT);
  assign bus.DONE   = (state_q == DONE);
  assign bus.ERR    = err_q;

endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
- Parametrised, multi-cycle shift unit for the ALU datapath.
- Shifts one bit position per clock under a START/BUSY/DONE handshake.
- Generalises the 8-bit shift/rotate operations to any power-of-two WIDTH and adds arithmetic right shift.
- Sits beside the ALU; the control unit stalls the pipeline while BUSY is high.

Parameters:
- WIDTH, 8, operand/result width; power of two, >= 4.
- SHAMT_W, 8, width of shift-amount input DATA2.
- CNT_W, $clog2(WIDTH)+1, internal counter width (derived; not overridden).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  request; sampled only when BUSY=0.
- SELECT  input  4  operation code, sampled at accept.
- DATA1  input  WIDTH  operand to shift, sampled at accept.
- DATA2  input  SHAMT_W  unsigned shift amount, sampled at accept.
- RESULT  output  WIDTH  registered result; valid when DONE=1, held until next accept.
- BUSY  output  1  high while shifting; START is ignored.
- DONE  output  1  one-cycle pulse; RESULT is final.
- ERR  output  1  pulses with DONE when SELECT was unsupported.

Behaviour:
- Reset, sampled on a rising CLK with RESET=1:
  - state=IDLE; RESULT=0, BUSY=0, DONE=0, ERR=0; counter=0.
  - Applies mid-operation too; the in-flight shift is discarded with no DONE.
- Select codes:
  - 4'b0100 SRL (logical right).
  - 4'b0101 SLL (logical left).
  - 4'b0110 ROR (rotate right).
  - 4'b0111 SRA (arithmetic right, MSB fill).
  - Any other code: unsupported.
- Accept: rising edge with START=1 and BUSY=0 (state IDLE or DONE).
  - RESULT register <= DATA1.
  - Latch op; compute effective count EFF.
  - Operand/select changes after accept are ignored.
- EFF rules:
  - SRL/SLL/SRA: EFF = min(DATA2, WIDTH). WIDTH single-bit steps give all-zero (logical) or all-sign (SRA).
  - ROR: EFF = DATA2 mod WIDTH (low $clog2(WIDTH) bits).
  - Unsupported: EFF = 0 and ERR is flagged.
- States:
  - IDLE -> (accept, EFF>0) SHIFT, counter<=EFF.
  - IDLE -> (accept, EFF=0) DONE.
  - SHIFT: each edge applies a one-bit step to RESULT and decrements the counter; when the counter reaches 1 on that edge -> DONE.
  - DONE: DONE=1 and BUSY=0 for exactly one cycle. Next edge -> IDLE, or SHIFT/DONE if a new START is accepted there (back-to-back allowed).
- One-bit steps:
  - SRL {0,R[W-1:1]}.
  - SLL {R[W-2:0],0}.
  - ROR {R[0],R[W-1:1]}.
  - SRA {R[W-1],R[W-1:1]}.
- Timing:
  - BUSY=1 exactly while in SHIFT.
  - Latency: DONE is high in the cycle after edge (accept + EFF), i.e. EFF+1 cycles after the accept edge.
- ERR: high only in the DONE cycle of an unsupported op; RESULT = DATA1 unchanged.
- START while BUSY=1: ignored, not queued.
- RESET and START on the same edge: reset wins.

Decomposition:
- Package shifter_pkg:
  - Select-code localparams SEL_SRL/SEL_SLL/SEL_ROR/SEL_SRA.
  - State enum {IDLE, SHIFT, DONE}.
  - Function computing EFF from (op, amount, WIDTH).
- Sub-module shift_step: combinational one-bit step, parameter WIDTH, inputs op and R, output next R. The top level holds the FSM, counter and result register.

Test Plan:
1. WIDTH=8, SRL, DATA1=8'hB4, DATA2=3 -> RESULT=8'h16; BUSY high 3 cycles; DONE in the 4th cycle after accept; ERR=0.
2. SRA, DATA1=8'h90, DATA2=2 -> 8'hE4. SRA with DATA2=200 -> 8'hFF after 8 shift cycles. SLL, DATA1=8'hFF, DATA2=9 -> 8'h00 after 8 shift cycles.
3. ROR, DATA1=8'h81, DATA2=9 -> EFF=1, RESULT=8'hC0, DONE 2 cycles after accept. ROR with DATA2=8 -> 8'h81, DONE the cycle after accept.
4. SELECT=4'b0010, DATA1=8'h5A -> DONE and ERR pulse together the cycle after accept; RESULT=8'h5A.
5. Mid-SHIFT: toggle START/DATA1 -> ignored. Then assert RESET for one edge -> BUSY=0, RESULT=0, no DONE. Next START accepted normally.
6. WIDTH=32: SLL of 32'h0000_0001 by 31 -> 32'h8000_0000. Then back-to-back START in the DONE cycle, ROR by 4 of 32'h1234_5678 -> 32'h8123_4567.
